// File: rtl/a2d_pkg.sv
// rtl/a2d_pkg.sv - shared states, channel numbers and command-format constants for a2d_sched
package a2d_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CMD  = 3'd1;
    localparam logic [2:0] ST_GAP  = 3'd2;
    localparam logic [2:0] ST_READ = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [2:0] CH_LFT   = 3'd0;
    localparam logic [2:0] CH_RGHT  = 3'd4;
    localparam logic [2:0] CH_STEER = 3'd5;
    localparam logic [2:0] CH_BATT  = 3'd6;

    localparam logic [1:0]  CMD_PREFIX = 2'b00;
    localparam logic [10:0] CMD_PAD    = 11'h000;
    localparam logic [15:0] CMD_READ   = 16'h0000;

    function automatic logic [2:0] chan_of(input logic [1:0] idx);
        case (idx)
            2'd0:    return CH_LFT;
            2'd1:    return CH_RGHT;
            2'd2:    return CH_STEER;
            default: return CH_BATT;
        endcase
    endfunction

    function automatic logic [15:0] conv_cmd(input logic [2:0] ch);
        return {CMD_PREFIX, ch, CMD_PAD};
    endfunction

    // Running average, summed at 13 bits so the carry survives before the halving.
    function automatic logic [11:0] ld_avg(input logic [11:0] old_val, input logic [11:0] samp);
        logic [12:0] sum;
        sum = {1'b0, old_val} + {1'b0, samp};
        return sum[12:1];
    endfunction

endpackage

// File: rtl/a2d_tmo_cnt.sv
// rtl/a2d_tmo_cnt.sv - 16-bit SPI response timeout counter with terminal-count flag
module a2d_tmo_cnt
    import a2d_pkg::*;
#(
    parameter int TMO_CYC = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= 16'h0000;
        end else if (en) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign tc = (cnt == 16'(TMO_CYC - 1));

endmodule

// File: rtl/a2d_sched.sv
// rtl/a2d_sched.sv - four-channel A2D sweep scheduler over a shared SPI master; A2D_LD_FILT_EN averages load channels
module a2d_sched
    import a2d_pkg::*;
#(
    parameter int GAP_CYC = 2,
    parameter int TMO_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nxt,
    output logic        spi_snd,
    output logic [15:0] spi_cmd,
    input  logic        spi_done,
    input  logic [15:0] spi_rd,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        all_vld,
    output logic        busy,
    output logic        a2d_err
);

    logic [2:0]  state;
    logic [1:0]  idx;
    logic [3:0]  gap_cnt;
    logic        issue;
    logic        waiting;
    logic        tmo_tc;
    logic        gap_end;
    logic [11:0] sample;
    logic [11:0] lft_next;
    logic [11:0] rght_next;
    logic [3:0]  unused_rd_hi;

    assign sample       = spi_rd[11:0];
    assign unused_rd_hi = spi_rd[15:12];

`ifdef A2D_LD_FILT_EN
    assign lft_next  = ld_avg(lft_ld, sample);
    assign rght_next = ld_avg(rght_ld, sample);
`else
    assign lft_next  = sample;
    assign rght_next = sample;
`endif

    assign waiting = (state == ST_CMD) || (state == ST_READ);
    assign gap_end = (state == ST_GAP) && (gap_cnt == 4'(GAP_CYC - 1));
    assign spi_cmd = (state == ST_CMD) ? conv_cmd(chan_of(idx)) : CMD_READ;

    // Every transition that launches a transaction; also restarts the timeout window.
    assign issue = ((state == ST_IDLE) && nxt) || gap_end ||
                   ((state == ST_READ) && spi_done && (idx != 2'd3));

    a2d_tmo_cnt #(.TMO_CYC(TMO_CYC)) u_tmo (
        .clk (clk),
        .rst (rst),
        .clr (issue),
        .en  (waiting),
        .tc  (tmo_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= 2'd0;
            gap_cnt   <= 4'd0;
            spi_snd   <= 1'b0;
            all_vld   <= 1'b0;
            busy      <= 1'b0;
            a2d_err   <= 1'b0;
            lft_ld    <= 12'h000;
            rght_ld   <= 12'h000;
            steer_pot <= 12'h000;
            batt      <= 12'h000;
        end else begin
            spi_snd <= issue;
            all_vld <= 1'b0;
            a2d_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (nxt) begin
                        idx   <= 2'd0;
                        busy  <= 1'b1;
                        state <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (spi_done) begin
                        gap_cnt <= 4'd0;
                        state   <= ST_GAP;
                    end else if (tmo_tc) begin
                        a2d_err <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gap_end) begin
                        gap_cnt <= 4'd0;
                        state   <= ST_READ;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                ST_READ: begin
                    if (spi_done) begin
                        case (idx)
                            2'd0:    lft_ld    <= lft_next;
                            2'd1:    rght_ld   <= rght_next;
                            2'd2:    steer_pot <= sample;
                            default: batt      <= sample;
                        endcase
                        if (idx != 2'd3) begin
                            idx   <= idx + 2'd1;
                            state <= ST_CMD;
                        end else begin
                            all_vld <= 1'b1;
                            state   <= ST_DONE;
                        end
                    end else if (tmo_tc) begin
                        a2d_err <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_sched.sv
// tb/tb_a2d_sched.sv - scoreboard bench for a2d_sched
module tb_a2d_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nxt = 1'b0;
    logic        spi_done = 1'b0;
    logic [15:0] spi_rd = 16'h0000;
    logic        spi_snd, all_vld, busy, a2d_err;
    logic [15:0] spi_cmd;
    logic [11:0] lft_ld, rght_ld, steer_pot, batt;

    logic        nxt_g = 1'b0;
    logic [1:0]  snd_g;
    logic [1:0]  done_g = 2'b00;
    logic [15:0] cmd_g [2];
    logic [11:0] gl [2], gr [2], gs [2], gb [2];
    logic [1:0]  vld_g, busy_g, err_g;

    a2d_sched #(.GAP_CYC(2), .TMO_CYC(16)) dut (
        .clk(clk), .rst(rst), .nxt(nxt), .spi_snd(spi_snd), .spi_cmd(spi_cmd),
        .spi_done(spi_done), .spi_rd(spi_rd), .lft_ld(lft_ld), .rght_ld(rght_ld),
        .steer_pot(steer_pot), .batt(batt), .all_vld(all_vld), .busy(busy), .a2d_err(a2d_err)
    );

    a2d_sched #(.GAP_CYC(1)) dut_g1 (
        .clk(clk), .rst(rst), .nxt(nxt_g), .spi_snd(snd_g[0]), .spi_cmd(cmd_g[0]),
        .spi_done(done_g[0]), .spi_rd(16'h0000), .lft_ld(gl[0]), .rght_ld(gr[0]),
        .steer_pot(gs[0]), .batt(gb[0]), .all_vld(vld_g[0]), .busy(busy_g[0]), .a2d_err(err_g[0])
    );

    a2d_sched #(.GAP_CYC(15)) dut_g15 (
        .clk(clk), .rst(rst), .nxt(nxt_g), .spi_snd(snd_g[1]), .spi_cmd(cmd_g[1]),
        .spi_done(done_g[1]), .spi_rd(16'h0000), .lft_ld(gl[1]), .rght_ld(gr[1]),
        .steer_pot(gs[1]), .batt(gb[1]), .all_vld(vld_g[1]), .busy(busy_g[1]), .a2d_err(err_g[1])
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    logic [15:0] cmdq [$];
    logic [47:0] resq [$];
    int          errq [$];
    logic [15:0] rdq  [$];
    int vld_cnt = 0, err_cnt = 0, snd_total = 0, last_snd = 0;
    int sweep_snd = 0, withhold = 0, gap_chk = 0;
    bit stray = 1'b0;
    logic [11:0] e_l = 0, e_r = 0, e_s = 0, e_b = 0;
    int rec [2];
    bit ph [2];

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [11:0] filt(input logic [11:0] old_val, input logic [11:0] samp);
        logic [12:0] s;
`ifdef A2D_LD_FILT_EN
        s = {1'b0, old_val} + {1'b0, samp};
        return s[12:1];
`else
        s = {1'b0, samp};
        return s[11:0];
`endif
    endfunction

    // Monitor: pops expectations whenever the DUT presents a command, result or error.
    always @(negedge clk) begin
        if (!rst) begin
            if (spi_snd) begin
                snd_total++;
                last_snd = cyc;
                if (cmdq.size() == 0) fail($sformatf("unexpected spi_snd cmd=%h", spi_cmd));
                else chk("spi_cmd", 48'(spi_cmd), 48'(cmdq.pop_front()));
            end
            if (all_vld) begin
                vld_cnt++;
                if (resq.size() == 0) fail("unexpected all_vld");
                else chk("results", {lft_ld, rght_ld, steer_pot, batt}, resq.pop_front());
            end
            if (a2d_err) begin
                err_cnt++;
                if (errq.size() == 0) fail("unexpected a2d_err");
                else chk("a2d_err spacing", 48'(cyc - last_snd), 48'(errq.pop_front()));
            end
            for (int k = 0; k < 2; k++) begin
                if (done_g[k] && ph[k]) rec[k] = cyc;
                if (snd_g[k]) begin
                    if (ph[k]) begin
                        gap_chk++;
                        chk($sformatf("gap spacing dut%0d", k), 48'(cyc - rec[k]), (k == 0) ? 48'd2 : 48'd16);
                    end
                    ph[k] = !ph[k];
                end
            end
        end
    end

    // Main SPI model: answers 3 cycles after each spi_snd unless told to withhold one.
    initial begin
        int pend;
        logic [15:0] pdata;
        pend = 0;
        pdata = 16'h0000;
        forever begin
            @(posedge clk);
            #2;
            spi_done = 1'b0;
            if (rst) begin
                pend = 0;
            end else if (stray) begin
                spi_done = 1'b1;
                spi_rd = 16'h0FFF;
                stray = 1'b0;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    spi_done = 1'b1;
                    spi_rd = pdata;
                end
            end
            if (!rst && spi_snd) begin
                sweep_snd++;
                if (sweep_snd != withhold) begin
                    pend = 3;
                    if (sweep_snd % 2 == 1) pdata = 16'hDEAD;
                    else pdata = (rdq.size() != 0) ? rdq.pop_front() : 16'h0000;
                end
            end
        end
    end

    // Fixed-latency responders for the two gap-spacing instances.
    initial begin
        logic [1:0] s0, s1;
        s0 = 2'b00;
        s1 = 2'b00;
        forever begin
            @(posedge clk);
            #2;
            done_g[0] = s0[1];
            done_g[1] = s1[1];
            s0 = {s0[0], snd_g[0]};
            s1 = {s1[0], snd_g[1]};
        end
    end

    initial begin
        #2000000;
        fail("watchdog expired");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    task automatic pulse_nxt();
        @(posedge clk); #1 nxt = 1'b1;
        @(posedge clk); #1 nxt = 1'b0;
    endtask

    task automatic wait_vld(input int n);
        int i;
        for (i = 0; i < 400 && vld_cnt < n; i++) @(posedge clk);
        if (vld_cnt < n) fail($sformatf("all_vld %0d not seen", n));
    endtask

    task automatic wait_err(input int n);
        int i;
        for (i = 0; i < 400 && err_cnt < n; i++) @(posedge clk);
        if (err_cnt < n) fail($sformatf("a2d_err %0d not seen", n));
    endtask

    task automatic wait_snd(input int n);
        int i;
        for (i = 0; i < 400 && snd_total < n; i++) @(posedge clk);
        if (snd_total < n) fail($sformatf("spi_snd %0d not seen", n));
    endtask

    task automatic start_sweep(input logic [11:0] a, input logic [11:0] b,
                               input logic [11:0] c, input logic [11:0] d);
        int chs [4];
        chs = '{0, 4, 5, 6};
        sweep_snd = 0;
        withhold = 0;
        rdq.push_back({4'h0, a}); rdq.push_back({4'h0, b});
        rdq.push_back({4'h0, c}); rdq.push_back({4'h0, d});
        for (int i = 0; i < 4; i++) begin
            cmdq.push_back(16'(chs[i] << 11));
            cmdq.push_back(16'h0000);
        end
        e_l = filt(e_l, a);
        e_r = filt(e_r, b);
        e_s = c;
        e_b = d;
        resq.push_back({e_l, e_r, e_s, e_b});
        pulse_nxt();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " results"}, {lft_ld, rght_ld, steer_pot, batt}, 48'h0);
        chk({tag, " flags"}, {44'h0, spi_snd, all_vld, busy, a2d_err}, 48'h0);
    endtask

    initial begin
        int base;
        int i;
        ph[0] = 1'b0; ph[1] = 1'b0; rec[0] = 0; rec[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        nxt_g = 1'b1;
        @(posedge clk); #1 nxt_g = 1'b0;

        // Sweep 1 with a second nxt issued during channel 4; it must be ignored.
        base = snd_total;
        start_sweep(12'hABC, 12'h123, 12'h800, 12'hFFF);
        wait_snd(base + 3);
        pulse_nxt();
        wait_vld(1);
        repeat (40) @(posedge clk);
        #1;
        chk("single all_vld", 48'(vld_cnt), 48'd1);
        chk("busy after sweep", 48'(busy), 48'd0);
`ifndef A2D_LD_FILT_EN
        chk("lft_ld raw", 48'(lft_ld), 48'hABC);
`endif

        // Timeout: the third transaction (channel 4 command) is never answered.
        sweep_snd = 0;
        withhold = 3;
        rdq.push_back(16'h0321);
        cmdq.push_back(16'h0000); cmdq.push_back(16'h0000); cmdq.push_back(16'h2000);
        e_l = filt(e_l, 12'h321);
        errq.push_back(16);
        pulse_nxt();
        wait_err(1);
        @(posedge clk); #1;
        chk("lft_ld after abort", 48'(lft_ld), 48'(e_l));
        chk("rght_ld after abort", 48'(rght_ld), 48'(e_r));
        chk("busy after abort", 48'(busy), 48'd0);
        chk("no all_vld on abort", 48'(vld_cnt), 48'd1);
        withhold = 0;

        // Reset during the GAP of channel 5, then a stray spi_done.
        sweep_snd = 0;
        rdq.push_back(16'h0111); rdq.push_back(16'h0222);
        cmdq.push_back(16'h0000); cmdq.push_back(16'h0000);
        cmdq.push_back(16'h2000); cmdq.push_back(16'h0000);
        cmdq.push_back(16'h2800);
        base = snd_total;
        pulse_nxt();
        wait_snd(base + 5);
        for (i = 0; i < 50; i++) begin
            @(posedge clk); #3;
            if (spi_done) break;
        end
        if (!spi_done) fail("channel 5 command response not seen");
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("mid-sweep reset");
        rst = 1'b0;
        e_l = 0; e_r = 0; e_s = 0; e_b = 0;
        stray = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk_all_zero("stray spi_done");

        // Two sweeps exercising the load-channel average.
        start_sweep(12'h400, 12'h010, 12'h020, 12'h030);
        wait_vld(2);
        start_sweep(12'h800, 12'h040, 12'h050, 12'h060);
        wait_vld(3);
        repeat (5) @(posedge clk);
        #1;
`ifdef A2D_LD_FILT_EN
        chk("filtered lft_ld", 48'(lft_ld), 48'h500);
`else
        chk("raw lft_ld", 48'(lft_ld), 48'h800);
`endif
        chk("batt raw", 48'(batt), 48'h060);

        repeat (20) @(posedge clk);
        #1;
        chk("cmd queue drained", 48'(cmdq.size()), 48'd0);
        chk("result queue drained", 48'(resq.size()), 48'd0);
        chk("error queue drained", 48'(errq.size()), 48'd0);
        chk("gap measurements", 48'(gap_chk), 48'd8);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/a2d_sched.md
A2D_SCHED -- requirements
Module: a2d_sched

Interface
REQ-001 Parameter GAP_CYC, default 2: idle cycles between the two SPI transactions of one conversion (range 1..15).
REQ-002 Parameter TMO_CYC, default 4096: cycles allowed for spi_done after spi_snd before the sweep aborts (range 16..65535).
REQ-003 clk  input  1  system clock; all logic on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 nxt  input  1  single-cycle request to start one four-channel sweep.
REQ-006 spi_snd  output  1  single-cycle start pulse to the shared SPI master.
REQ-007 spi_cmd  output  16  command word presented with spi_snd.
REQ-008 spi_done  input  1  single-cycle SPI transaction complete.
REQ-009 spi_rd  input  16  SPI read data, valid in the spi_done cycle.
REQ-010 lft_ld, rght_ld, steer_pot, batt  output  12 each  latest conversion results.
REQ-011 all_vld  output  1  single-cycle pulse when a sweep completes.
REQ-012 busy  output  1  high from the cycle after an accepted nxt until the sweep ends.
REQ-013 a2d_err  output  1  single-cycle pulse on timeout abort.

Function
REQ-014 Sweep order SHALL be channel 0 to lft_ld, 4 to rght_ld, 5 to steer_pot, 6 to batt.
REQ-015 The state machine SHALL have exactly these states: IDLE, CMD, GAP, READ, DONE.
REQ-016 IDLE with nxt=1: set channel index 0, assert busy, go to CMD.
REQ-017 nxt while busy SHALL be ignored; it is not queued.
REQ-018 CMD entry: one-cycle spi_snd with spi_cmd = {2'b00, ch[2:0], 11'h000}; on spi_done go to GAP; response data is discarded.
REQ-019 GAP: count GAP_CYC cycles, then go to READ.
REQ-020 READ entry: one-cycle spi_snd with spi_cmd = 16'h0000; on spi_done capture spi_rd[11:0] into the indexed output.
REQ-021 After the READ capture: if the index is below 3, increment it and go to CMD; otherwise go to DONE.
REQ-022 DONE SHALL last one cycle, pulse all_vld, deassert busy, and return to IDLE; nxt in DONE is ignored.
REQ-023 Each result output SHALL update only in its capture cycle and hold otherwise.
REQ-024 The timeout counter SHALL clear on every spi_snd and count while waiting in CMD or READ.
REQ-025 When the timeout counter reaches TMO_CYC-1: pulse a2d_err, return to IDLE, leave outputs unchanged, and do not pulse all_vld.
REQ-026 spi_done outside CMD or READ waits SHALL be ignored.
REQ-027 spi_done in the same cycle as the timeout terminal count SHALL win; there is no error.
REQ-028 Worst-case latency from nxt to all_vld SHALL be 1 + 4*(2 SPI transactions + GAP_CYC + 2) + 1 cycles, excluding SPI time.

Reset
REQ-029 rst SHALL force IDLE, index 0, timeout and gap counters to 0, all results to 12'h000, and spi_snd, all_vld, busy, a2d_err to 0.
REQ-030 rst mid-sweep SHALL abandon the sweep with no all_vld or a2d_err pulse; a late spi_done is ignored.

Configuration
REQ-031 With macro A2D_LD_FILT_EN defined, lft_ld and rght_ld capture SHALL be a running average: new = (old + sample) >> 1, computed at 13-bit width, truncated.
REQ-032 Without A2D_LD_FILT_EN, all channels SHALL capture the raw sample; steer_pot and batt are never filtered.

Structure
REQ-033 A shared package a2d_pkg SHALL hold the state enum, the channel-number constants (0, 4, 5, 6), and the 16-bit command-format constants.
REQ-034 One sub-module, a2d_tmo_cnt, SHALL implement the 16-bit timeout counter with clr, en, and terminal-count outputs.
REQ-035 The scheduler FSM, gap counter, and result registers SHALL live in a2d_sched.

Verification
REQ-036 Reset, then nxt with an SPI model returning 16'h0ABC, 16'h0123, 16'h0800, 16'h0FFF on the reads -> spi_cmd sequence 0000, 0000, 2000, 0000, 2800, 0000, 3000, 0000 hex; outputs ABC, 123, 800, FFF; one all_vld pulse.
REQ-037 Pulse nxt again during the second channel -> no second sweep; exactly one all_vld.
REQ-038 Withhold spi_done after the third spi_snd with TMO_CYC=16 -> a2d_err pulses 16 cycles later; lft_ld keeps its prior value; busy=0.
REQ-039 Assert rst in GAP of channel 5 -> all outputs 0 the next cycle; a stray spi_done afterwards produces no capture.
REQ-040 With A2D_LD_FILT_EN, two sweeps with lft samples 12'h400 then 12'h800 -> lft_ld 12'h200 then 12'h500; batt raw.
REQ-041 GAP_CYC=1 and GAP_CYC=15 -> the measured spacing from the CMD-phase spi_done to the READ-phase spi_snd equals GAP_CYC+1 cycles.
